// File: rtl/bch_syndrome_gen.sv
// Streaming BCH syndrome generator: accumulates S1..S8 per frame and hands them to the decoder through a one-deep buffer.
// Optional zero-syndrome flags are compiled in with `define SYNGEN_ZERO_FLAG_EN.
module bch_syndrome_gen #(
    parameter int SYM_W = 10,
    parameter int CNT_W = 10
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_code,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_data,
    output logic [SYM_W-1:0] o_S1,
    output logic [SYM_W-1:0] o_S2,
    output logic [SYM_W-1:0] o_S3,
    output logic [SYM_W-1:0] o_S4,
    output logic [SYM_W-1:0] o_S5,
    output logic [SYM_W-1:0] o_S6,
    output logic [SYM_W-1:0] o_S7,
    output logic [SYM_W-1:0] o_S8,
    output logic [1:0]       o_code,
    output logic             o_syn_valid,
`ifdef SYNGEN_ZERO_FLAG_EN
    output logic             o_zero_a,
    output logic             o_zero_b,
`endif
    input  logic             i_syn_take
);

    typedef enum logic {ST_ACC = 1'b0, ST_HOLD = 1'b1} state_t;

    // Multiply by alpha (= x) in the field chosen by code.
    function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] v, input logic [1:0] code);
        logic [9:0] x;
        logic [9:0] r;
        x = v[9:0];
        case (code)
            2'b00:   r = {4'b0000, x[4:0], 1'b0} ^ (x[5] ? 10'h003 : 10'h000);
            2'b01:   r = {2'b00, x[6:0], 1'b0} ^ (x[7] ? 10'h01D : 10'h000);
            default: r = {x[8:0], 1'b0} ^ (x[9] ? 10'h009 : 10'h000);
        endcase
        return SYM_W'(r);
    endfunction

    function automatic logic [SYM_W-1:0] gf_mult(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b,
                                                 input logic [1:0] code);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] m;
        p = '0;
        m = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (b[i]) p = p ^ m;
            else      p = p;
            m = gf_xtime(m, code);
        end
        return p;
    endfunction

    function automatic logic [SYM_W-1:0] gf_apow(input int e, input logic [1:0] code);
        logic [SYM_W-1:0] v;
        v = SYM_W'(1);
        for (int i = 0; i < 16; i++) begin
            if (i < e) v = gf_xtime(v, code);
            else       v = v;
        end
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] last_idx(input logic [1:0] code);
        case (code)
            2'b00:   return CNT_W'(62);
            2'b01:   return CNT_W'(254);
            default: return CNT_W'(511);
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       buf_code_q, buf_code_d;
    logic             syn_valid_q, syn_valid_d;
    logic [SYM_W-1:0] acc_q [8];
    logic [SYM_W-1:0] acc_d [8];
    logic [SYM_W-1:0] buf_q [8];
    logic [SYM_W-1:0] buf_d [8];
    logic [SYM_W-1:0] acc_upd_s [8];
    logic [1:0]       eff_code_s;
    logic             accept_s, last_beat_s, buf_free_s, pad_bit_s, load_s;
`ifdef SYNGEN_ZERO_FLAG_EN
    logic             zero_a_q, zero_a_d, zero_b_q, zero_b_d;
`endif

    // The first beat of a frame already uses the incoming code, before it is latched.
    assign eff_code_s  = (cnt_q == '0) ? i_code : code_q;
    assign accept_s    = i_valid && o_ready;
    assign last_beat_s = (cnt_q == last_idx(eff_code_s));
    assign buf_free_s  = !syn_valid_q || i_syn_take;
    assign pad_bit_s   = i_data[1] && (cnt_q != '0);

    // Per-beat Horner step for all eight syndromes.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            if (!eff_code_s[1]) begin
                if (k < 4) acc_upd_s[k] = gf_mult(acc_q[k], gf_apow(k + 1, eff_code_s), eff_code_s) ^ SYM_W'(i_data[1]);
                else       acc_upd_s[k] = gf_mult(acc_q[k], gf_apow(k - 3, eff_code_s), eff_code_s) ^ SYM_W'(i_data[0]);
            end else begin
                acc_upd_s[k] = gf_mult(acc_q[k], gf_apow(2 * (k + 1), eff_code_s), eff_code_s)
                             ^ (pad_bit_s ? gf_apow(k + 1, eff_code_s) : '0) ^ SYM_W'(i_data[0]);
            end
        end
    end

    // Next-state logic: HOLD parks a finished frame until the buffer is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: begin
                if (accept_s && last_beat_s && !buf_free_s) state_d = ST_HOLD;
                else                                        state_d = ST_ACC;
            end
            ST_HOLD: begin
                if (i_syn_take) state_d = ST_ACC;
                else            state_d = ST_HOLD;
            end
            default: state_d = ST_ACC;
        endcase
    end

    // FSM output decode.
    always_comb begin
        o_ready = (state_q == ST_ACC);
    end

    // Datapath next values: counter, code latch, accumulators and output buffer.
    always_comb begin
        cnt_d       = cnt_q;
        code_d      = code_q;
        acc_d       = acc_q;
        buf_d       = buf_q;
        buf_code_d  = buf_code_q;
        syn_valid_d = syn_valid_q;
        load_s      = 1'b0;
        case (state_q)
            ST_ACC: begin
                if (accept_s) begin
                    if (cnt_q == '0) code_d = i_code;
                    else             code_d = code_q;
                    if (last_beat_s) begin
                        cnt_d = '0;
                        if (buf_free_s) begin
                            buf_d      = acc_upd_s;
                            buf_code_d = eff_code_s;
                            acc_d      = '{default: '0};
                            load_s     = 1'b1;
                        end else begin
                            acc_d = acc_upd_s;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        acc_d = acc_upd_s;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                if (load_s)                          syn_valid_d = 1'b1;
                else if (i_syn_take && syn_valid_q)  syn_valid_d = 1'b0;
                else                                 syn_valid_d = syn_valid_q;
            end
            ST_HOLD: begin
                if (i_syn_take) begin
                    buf_d      = acc_q;
                    buf_code_d = code_q;
                    acc_d      = '{default: '0};
                    load_s     = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: load_s = 1'b0;
        endcase
`ifdef SYNGEN_ZERO_FLAG_EN
        zero_a_d = zero_a_q;
        zero_b_d = zero_b_q;
        if (load_s) begin
            zero_a_d = ((buf_d[0] | buf_d[1] | buf_d[2] | buf_d[3]) == '0);
            zero_b_d = ((buf_d[4] | buf_d[5] | buf_d[6] | buf_d[7]) == '0);
            if (buf_code_d[1]) begin
                zero_a_d = zero_a_d && zero_b_d;
                zero_b_d = zero_a_d;
            end else begin
                zero_b_d = zero_b_d;
            end
        end else begin
            zero_a_d = zero_a_q;
        end
`endif
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_ACC;
        else          state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q       <= '0;
            code_q      <= 2'b00;
            buf_code_q  <= 2'b00;
            syn_valid_q <= 1'b0;
            acc_q       <= '{default: '0};
            buf_q       <= '{default: '0};
`ifdef SYNGEN_ZERO_FLAG_EN
            zero_a_q    <= 1'b0;
            zero_b_q    <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            buf_code_q  <= buf_code_d;
            syn_valid_q <= syn_valid_d;
            acc_q       <= acc_d;
            buf_q       <= buf_d;
`ifdef SYNGEN_ZERO_FLAG_EN
            zero_a_q    <= zero_a_d;
            zero_b_q    <= zero_b_d;
`endif
        end
    end

    assign o_S1        = buf_q[0];
    assign o_S2        = buf_q[1];
    assign o_S3        = buf_q[2];
    assign o_S4        = buf_q[3];
    assign o_S5        = buf_q[4];
    assign o_S6        = buf_q[5];
    assign o_S7        = buf_q[6];
    assign o_S8        = buf_q[7];
    assign o_code      = buf_code_q;
    assign o_syn_valid = syn_valid_q;
`ifdef SYNGEN_ZERO_FLAG_EN
    assign o_zero_a    = zero_a_q;
    assign o_zero_b    = zero_b_q;
`endif

endmodule

// File: tb/tb_bch_syndrome_gen.sv
// Directed testbench for bch_syndrome_gen; expected syndromes are hand-computed powers of alpha.
module tb_bch_syndrome_gen;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [1:0] i_code = 2'b00;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic [1:0] i_data = 2'b00;
    logic [9:0] o_S1, o_S2, o_S3, o_S4, o_S5, o_S6, o_S7, o_S8;
    logic [1:0] o_code;
    logic       o_syn_valid;
    logic       i_syn_take = 1'b0;
`ifdef SYNGEN_ZERO_FLAG_EN
    logic       o_zero_a, o_zero_b;
`endif
    logic [9:0] s [8];
    logic [9:0] exp_s [8];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign s[0] = o_S1; assign s[1] = o_S2; assign s[2] = o_S3; assign s[3] = o_S4;
    assign s[4] = o_S5; assign s[5] = o_S6; assign s[6] = o_S7; assign s[7] = o_S8;

    bch_syndrome_gen #(.SYM_W(10), .CNT_W(10)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_code(i_code), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .o_S1(o_S1), .o_S2(o_S2), .o_S3(o_S3), .o_S4(o_S4), .o_S5(o_S5),
        .o_S6(o_S6), .o_S7(o_S7), .o_S8(o_S8), .o_code(o_code), .o_syn_valid(o_syn_valid),
`ifdef SYNGEN_ZERO_FLAG_EN
        .o_zero_a(o_zero_a), .o_zero_b(o_zero_b),
`endif
        .i_syn_take(i_syn_take)
    );

    // One frame; i_code is garbled after beat 0 to show the latch ignores it.
    task automatic run_frame(input logic [1:0] code, input int n, input int idx, input logic [1:0] val,
                             input int idx2, input logic [1:0] val2, input bit take_last, input int gap_at);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                i_valid = 1'b0; i_data = 2'b11;
                repeat (2) @(posedge clk);
                #1;
            end
            i_valid    = 1'b1;
            i_code     = (i == 0) ? code : ~code;
            i_data     = (i == idx) ? val : ((i == idx2) ? val2 : 2'b00);
            i_syn_take = take_last && (i == n - 1);
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_data = 2'b00; i_syn_take = 1'b0; i_code = code;
    endtask

    task automatic pulse_take();
        i_syn_take = 1'b1;
        @(posedge clk); #1;
        i_syn_take = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b1; i_data = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (o_syn_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_syn_valid); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        checks++; if (o_code !== 2'b00) begin errors++; $display("FAIL reset_code got %b exp 00", o_code); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] !== 10'h000) begin errors++; $display("FAIL reset_S%0d got %h exp 000", k + 1, s[k]); end
        end
        i_valid = 1'b0; i_data = 2'b00; i_rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_code00();
        run_frame(2'b00, 63, 62, 2'b10, -1, 2'b00, 1'b0, -1);
        exp_s = '{10'h001, 10'h001, 10'h001, 10'h001, 10'h000, 10'h000, 10'h000, 10'h000};
        checks++; if (o_syn_valid !== 1'b1) begin errors++; $display("FAIL c00_deg0_valid got %b exp 1", o_syn_valid); end
        checks++; if (o_code !== 2'b00) begin errors++; $display("FAIL c00_deg0_code got %b exp 00", o_code); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] !== exp_s[k]) begin errors++; $display("FAIL c00_deg0_S%0d got %h exp %h", k + 1, s[k], exp_s[k]); end
        end
`ifdef SYNGEN_ZERO_FLAG_EN
        checks++; if ({o_zero_a, o_zero_b} !== 2'b01) begin errors++; $display("FAIL c00_zero got %b%b exp 01", o_zero_a, o_zero_b); end
`endif
        @(posedge clk); #1;
        checks++; if (o_syn_valid !== 1'b1 || o_S1 !== 10'h001) begin errors++; $display("FAIL c00_stable got %b/%h exp 1/001", o_syn_valid, o_S1); end
        pulse_take();
        checks++; if (o_syn_valid !== 1'b0) begin errors++; $display("FAIL c00_take got %b exp 0", o_syn_valid); end
        pulse_take();
        checks++; if (o_syn_valid !== 1'b0) begin errors++; $display("FAIL c00_idle_take got %b exp 0", o_syn_valid); end
        // A degree 1, B degree 6 (exercises x^6 = x+1), with an idle gap mid-frame.
        run_frame(2'b00, 63, 61, 2'b10, 56, 2'b01, 1'b0, 30);
        exp_s = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h003, 10'h005, 10'h00F, 10'h011};
        checks++; if (o_syn_valid !== 1'b1) begin errors++; $display("FAIL c00_deg1_valid got %b exp 1", o_syn_valid); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] !== exp_s[k]) begin errors++; $display("FAIL c00_deg1_S%0d got %h exp %h", k + 1, s[k], exp_s[k]); end
        end
        pulse_take();
    endtask

    task automatic test_code10();
        // Degree 1 set; first beat's upper bit is padding and must be ignored.
        run_frame(2'b10, 512, 511, 2'b10, 0, 2'b10, 1'b0, 200);
        exp_s = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h080, 10'h100};
        checks++; if (o_syn_valid !== 1'b1) begin errors++; $display("FAIL c10_deg1_valid got %b exp 1", o_syn_valid); end
        checks++; if (o_code !== 2'b10) begin errors++; $display("FAIL c10_code got %b exp 10", o_code); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] !== exp_s[k]) begin errors++; $display("FAIL c10_deg1_S%0d got %h exp %h", k + 1, s[k], exp_s[k]); end
        end
        pulse_take();
        // Degree 10 -> S_j = alpha^(10j) in GF(2^10).
        run_frame(2'b10, 512, 506, 2'b01, -1, 2'b00, 1'b0, -1);
        exp_s = '{10'h009, 10'h041, 10'h249, 10'h025, 10'h10D, 10'h177, 10'h2DD, 10'h018};
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] !== exp_s[k]) begin errors++; $display("FAIL c10_deg10_S%0d got %h exp %h", k + 1, s[k], exp_s[k]); end
        end
        pulse_take();
    endtask

    task automatic test_back_to_back();
        run_frame(2'b01, 255, 252, 2'b10, -1, 2'b00, 1'b0, -1);
        checks++; if (o_syn_valid !== 1'b1 || o_ready !== 1'b1) begin errors++; $display("FAIL b2b_f1 got %b%b exp 11", o_syn_valid, o_ready); end
        run_frame(2'b01, 255, 254, 2'b01, -1, 2'b00, 1'b0, -1);
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_ready got %b exp 0", o_ready); end
        exp_s = '{10'h004, 10'h010, 10'h040, 10'h01D, 10'h000, 10'h000, 10'h000, 10'h000};
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] !== exp_s[k]) begin errors++; $display("FAIL b2b_f1_S%0d got %h exp %h", k + 1, s[k], exp_s[k]); end
        end
        // Beats offered during HOLD must not be accepted.
        i_valid = 1'b1; i_data = 2'b11; i_code = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        i_valid = 1'b0; i_data = 2'b00;
        checks++; if (o_ready !== 1'b0 || o_syn_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b%b exp 01", o_ready, o_syn_valid); end
        pulse_take();
        checks++; if (o_syn_valid !== 1'b1 || o_ready !== 1'b1) begin errors++; $display("FAIL b2b_take got %b%b exp 11", o_syn_valid, o_ready); end
        checks++; if (o_code !== 2'b01) begin errors++; $display("FAIL b2b_code got %b exp 01", o_code); end
        exp_s = '{10'h000, 10'h000, 10'h000, 10'h000, 10'h001, 10'h001, 10'h001, 10'h001};
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] !== exp_s[k]) begin errors++; $display("FAIL b2b_f2_S%0d got %h exp %h", k + 1, s[k], exp_s[k]); end
        end
    endtask

    task automatic test_take_with_last();
        run_frame(2'b00, 63, 62, 2'b10, -1, 2'b00, 1'b1, -1);
        checks++; if (o_syn_valid !== 1'b1 || o_ready !== 1'b1) begin errors++; $display("FAIL twl_flags got %b%b exp 11", o_syn_valid, o_ready); end
        checks++; if (o_code !== 2'b00) begin errors++; $display("FAIL twl_code got %b exp 00", o_code); end
        checks++; if (o_S1 !== 10'h001 || o_S5 !== 10'h000) begin errors++; $display("FAIL twl_S got %h/%h exp 001/000", o_S1, o_S5); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 100; i++) begin
            i_valid = 1'b1; i_code = 2'b10; i_data = 2'b11;
            @(posedge clk); #1;
        end
        i_valid = 1'b0; i_data = 2'b00; i_rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_syn_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flags got %b%b exp 01", o_syn_valid, o_ready); end
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        run_frame(2'b10, 512, -1, 2'b00, -1, 2'b00, 1'b0, -1);
        checks++; if (o_syn_valid !== 1'b1 || o_code !== 2'b10) begin errors++; $display("FAIL rstmid_frame got %b/%b exp 1/10", o_syn_valid, o_code); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (s[k] !== 10'h000) begin errors++; $display("FAIL rstmid_S%0d got %h exp 000", k + 1, s[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_code00();
        test_code10();
        test_back_to_back();
        test_take_with_last();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
